// File: rtl/wb_rr_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_rr_arbiter_pkg: Wishbone response encoding and shared bus constants.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_RESP_NONE = 2'd0,
    WB_RESP_ACK  = 2'd1,
    WB_RESP_ERR  = 2'd2,
    WB_RESP_RTY  = 2'd3
  } wb_resp_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // Ack outranks err, which outranks rty, should a slave ever raise several.
  function automatic wb_resp_e wb_resp_encode(input logic ack, input logic err, input logic rty);
    if (ack) begin
      return WB_RESP_ACK;
    end else if (err) begin
      return WB_RESP_ERR;
    end else if (rty) begin
      return WB_RESP_RTY;
    end
    return WB_RESP_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, scans upward from last+1.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int off = N; off >= 1; off--) begin
      cand = {1'b0, last_i} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_rr_arbiter: round-robin Wishbone master arbiter with cyc locking.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int DATA_WIDTH      = 128,
  parameter int BUS_GRANULARITY = 32,
  parameter int TIMEOUT         = DEFAULT_TIMEOUT,
  localparam int SEL_WIDTH      = DATA_WIDTH / BUS_GRANULARITY,
  localparam int IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*32-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  output logic [DATA_WIDTH-1:0]         m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [31:0]                   wb_adr_o,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  output logic                          wb_we_o,
  output logic [SEL_WIDTH-1:0]          wb_sel_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  input  logic                          wb_rty_i,
  output logic                          wb_cyc_o,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   busy;
  logic                   sel_cyc, sel_stb, sel_we;
  logic [31:0]            sel_adr;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic [SEL_WIDTH-1:0]   sel_sel;
  wb_resp_e               resp;
  logic                   got_resp;
  logic                   wd_hit;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // last_q doubles as the owner index while BUSY.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (IDX_W'(k) == last_q) begin
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_we  = m_we_i[k];
        sel_adr = m_adr_i[k*32 +: 32];
        sel_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_sel = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign wb_cyc_o = busy & sel_cyc;
  assign wb_stb_o = busy & sel_cyc & sel_stb;
  assign wb_we_o  = busy & sel_we;
  assign wb_adr_o = busy ? sel_adr : '0;
  assign wb_dat_o = busy ? sel_dat : '0;
  assign wb_sel_o = busy ? sel_sel : '0;

  assign resp     = wb_resp_encode(wb_ack_i, wb_err_i, wb_rty_i);
  assign got_resp = (resp != WB_RESP_NONE);
  assign wd_hit   = wb_stb_o & ~got_resp & (wd_q == WD_W'(TIMEOUT - 1));

  // grant_q is all-zero in IDLE, so it masks the responses on its own.
  assign m_dat_o   = wb_dat_i;
  assign m_ack_o   = grant_q & {NUM_MASTERS{wb_ack_i}};
  assign m_err_o   = grant_q & {NUM_MASTERS{wb_err_i | wd_hit}};
  assign m_rty_o   = grant_q & {NUM_MASTERS{wb_rty_i}};
  assign timeout_o = wd_hit;
  assign grant_o   = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (pick_found) begin
          state_d = S_BUSY;
          grant_d = NUM_MASTERS'(1) << pick_idx;
          last_d  = pick_idx;
        end
      end
      S_BUSY: begin
        if (!sel_cyc || wd_hit) begin
          state_d = S_IDLE;
          grant_d = '0;
          wd_d    = '0;
        end else if (wb_stb_o && !got_resp) begin
          wd_d = wd_q + WD_W'(1);
        end else begin
          wd_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int DW = 128;
  localparam int GR = 32;
  localparam int TO = 8;
  localparam int SW = DW / GR;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*32-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM-1:0]     m_we, m_stb, m_cyc;
  logic [NM*SW-1:0]  m_sel;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic [31:0]       wb_adr_o;
  logic [DW-1:0]     wb_dat_o, wb_dat_i;
  logic              wb_we_o;
  logic [SW-1:0]     wb_sel_o;
  logic              wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i, wb_cyc_o;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS     (NM),
    .DATA_WIDTH      (DW),
    .BUS_GRANULARITY (GR),
    .TIMEOUT         (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_we_i    (m_we),
    .m_sel_i   (m_sel),
    .m_stb_i   (m_stb),
    .m_cyc_i   (m_cyc),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i),
    .wb_cyc_o  (wb_cyc_o),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Entered at the start of a granted cycle: ack one beat, release, idle, re-request.
  task automatic serve(input logic [NM-1:0] exp, input string tag);
    wb_ack_i = 1'b1;
    settle();
    check({tag, "_grant"}, 128'(grant_o), 128'(exp));
    check({tag, "_ack"}, 128'(m_ack_o), 128'(exp));
    next_cycle();
    wb_ack_i = 1'b0;
    m_cyc = m_cyc & ~exp;
    m_stb = m_stb & ~exp;
    settle();
    check({tag, "_rel_cyc"}, 128'(wb_cyc_o), 128'(0));
    next_cycle();
    settle();
    check({tag, "_idle_grant"}, 128'(grant_o), 128'(0));
    m_cyc = m_cyc | exp;
    m_stb = m_stb | exp;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0; m_stb = '0; m_cyc = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    #12;
    check("rst_cyc", 128'(wb_cyc_o), 128'(0));
    check("rst_stb", 128'(wb_stb_o), 128'(0));
    check("rst_grant", 128'(grant_o), 128'(0));
    check("rst_adr", 128'(wb_adr_o), 128'(0));
    check("rst_ack", 128'(m_ack_o), 128'(0));
    check("rst_tmo", 128'(timeout_o), 128'(0));
    rst = 1'b0;

    // Single request from master 1
    next_cycle();
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_adr[32 +: 32] = 32'h0000_1000;
    m_dat[DW +: DW] = {4{32'hA5A5_0001}};
    m_sel[SW +: SW] = 4'hC;
    settle();
    check("t1_c0_cyc", 128'(wb_cyc_o), 128'(0));
    next_cycle();
    settle();
    check("t1_c1_cyc", 128'(wb_cyc_o), 128'(1));
    check("t1_c1_adr", 128'(wb_adr_o), 128'(32'h0000_1000));
    check("t1_c1_grant", 128'(grant_o), 128'(2'b10));
    check("t1_c1_we", 128'(wb_we_o), 128'(1));
    check("t1_c1_dat", wb_dat_o, {4{32'hA5A5_0001}});
    check("t1_c1_sel", 128'(wb_sel_o), 128'(4'hC));
    next_cycle();
    settle();
    check("t1_c2_ack", 128'(m_ack_o), 128'(0));
    next_cycle();
    wb_ack_i = 1'b1;
    wb_dat_i = {4{32'h1234_5678}};
    settle();
    check("t1_c3_ack", 128'(m_ack_o), 128'(2'b10));
    check("t1_c3_err", 128'(m_err_o), 128'(0));
    check("t1_c3_rdat", m_dat_o, {4{32'h1234_5678}});
    next_cycle();
    wb_ack_i = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    settle();
    check("t1_c4_ack", 128'(m_ack_o), 128'(0));
    check("t1_c4_cyc", 128'(wb_cyc_o), 128'(0));
    next_cycle();
    settle();
    check("t1_c5_grant", 128'(grant_o), 128'(0));

    // Contention from reset: alternate 0,1,0,1
    rst = 1'b1;
    settle();
    rst = 1'b0;
    next_cycle();
    m_cyc = 2'b11; m_stb = 2'b11;
    settle();
    next_cycle();
    serve(2'b01, "rr0");
    serve(2'b10, "rr1");
    serve(2'b01, "rr2");
    serve(2'b10, "rr3");

    // Lock: master 0 does 3 beats while master 1 waits
    for (int b = 0; b < 3; b++) begin
      wb_ack_i = 1'b1;
      settle();
      check($sformatf("lock_b%0d_grant", b), 128'(grant_o), 128'(2'b01));
      check($sformatf("lock_b%0d_ack", b), 128'(m_ack_o), 128'(2'b01));
      next_cycle();
      wb_ack_i = 1'b0;
      settle();
      check($sformatf("lock_w%0d_grant", b), 128'(grant_o), 128'(2'b01));
      next_cycle();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    check("lock_rel_cyc", 128'(wb_cyc_o), 128'(0));
    next_cycle();
    settle();
    check("lock_idle_grant", 128'(grant_o), 128'(0));
    next_cycle();
    settle();
    check("lock_m1_grant", 128'(grant_o), 128'(2'b10));

    // Timeout: master 1 strobes, slave never answers; fires in 8th stb cycle
    for (int s = 1; s <= TO; s++) begin
      if (s > 1) begin
        next_cycle();
        settle();
      end
      check($sformatf("to_s%0d_tmo", s), 128'(timeout_o), 128'((s == TO) ? 1 : 0));
      check($sformatf("to_s%0d_err", s), 128'(m_err_o), 128'((s == TO) ? 2'b10 : 2'b00));
    end
    next_cycle();
    settle();
    check("to_after_cyc", 128'(wb_cyc_o), 128'(0));
    check("to_after_grant", 128'(grant_o), 128'(0));
    next_cycle();
    settle();
    check("to_regrant", 128'(grant_o), 128'(2'b10));

    // Race: ack lands in the would-be fire cycle
    for (int s = 1; s <= TO; s++) begin
      if (s > 1) begin
        next_cycle();
        wb_ack_i = (s == TO);
        settle();
      end
    end
    check("race_ack", 128'(m_ack_o), 128'(2'b10));
    check("race_err", 128'(m_err_o), 128'(0));
    check("race_tmo", 128'(timeout_o), 128'(0));
    next_cycle();
    wb_ack_i = 1'b0;
    settle();
    check("race_still_grant", 128'(grant_o), 128'(2'b10));
    check("race_still_cyc", 128'(wb_cyc_o), 128'(1));

    // Async reset mid-transfer while master 0 owns the bus
    m_cyc = 2'b01; m_stb = 2'b01;
    next_cycle();
    settle();
    next_cycle();
    settle();
    check("ar_pre_grant", 128'(grant_o), 128'(2'b01));
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    check("ar_cyc", 128'(wb_cyc_o), 128'(0));
    check("ar_stb", 128'(wb_stb_o), 128'(0));
    check("ar_grant", 128'(grant_o), 128'(0));
    rst = 1'b0;
    next_cycle();
    settle();
    check("ar_first_grant", 128'(grant_o), 128'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
